// File: rtl/fb_write_arbiter.sv
// Framebuffer write arbiter: round-robin A/B grants outside the visible area,
// plus an optional frame-start clear sequencer (FB_CLEAR_EN).
// Ports: clk, reset, display_on, vpos; a_req/a_addr/a_data/a_ack;
//   b_req/b_addr/b_data/b_ack; we/addr/ram_d (registered RAM port); clearing.
module fb_write_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              display_on,
  input  logic [8:0]        vpos,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] ram_d,
  output logic              clearing
);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE_A, WRITE_B, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE_A, WRITE_B} state_t;
`endif

  state_t state_q, state_d;
  logic we_d, a_ack_d, b_ack_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic last_b_q, last_b_d;
  logic [8:0] vpos_q, vpos_qq;
  logic frame_start;
  logic clear_go;

  // Frame start: registered scanline just wrapped from nonzero to 0.
  assign frame_start = (vpos_q == 9'd0) && (vpos_qq != 9'd0);

`ifdef FB_CLEAR_EN
  // Extra MSB marks "all addresses written".
  logic [ADDR_W:0] clr_q, clr_d;
  assign clear_go = frame_start;
  assign clearing = (state_q == CLEAR);
`else
  logic unused_fs;
  assign unused_fs = frame_start;
  assign clear_go  = 1'b0;
  assign clearing  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    addr_d   = addr;
    data_d   = ram_d;
    last_b_d = last_b_q;
`ifdef FB_CLEAR_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_go) begin
`ifdef FB_CLEAR_EN
          state_d = CLEAR;
          clr_d   = '0;
`endif
        end else if (!display_on && (a_req || b_req)) begin
          // Tie goes to whoever was not granted last.
          if (a_req && (!b_req || last_b_q)) begin
            state_d  = WRITE_A;
            we_d     = 1'b1;
            a_ack_d  = 1'b1;
            addr_d   = a_addr;
            data_d   = a_data;
            last_b_d = 1'b0;
          end else begin
            state_d  = WRITE_B;
            we_d     = 1'b1;
            b_ack_d  = 1'b1;
            addr_d   = b_addr;
            data_d   = b_data;
            last_b_d = 1'b1;
          end
        end
      end
      WRITE_A, WRITE_B: begin
        state_d = IDLE;
`ifdef FB_CLEAR_EN
        if (clear_go) begin
          state_d = CLEAR;
          clr_d   = '0;
        end
`endif
      end
`ifdef FB_CLEAR_EN
      CLEAR: begin
        // Stay one cycle past the last write so we=1 only shows in CLEAR.
        if (clr_q[ADDR_W]) begin
          state_d = IDLE;
        end else if (!display_on) begin
          we_d   = 1'b1;
          addr_d = clr_q[ADDR_W-1:0];
          data_d = CLEAR_VAL;
          clr_d  = clr_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we       <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      addr     <= '0;
      ram_d    <= '0;
      last_b_q <= 1'b1;
      vpos_q   <= 9'd0;
      vpos_qq  <= 9'd0;
    end else begin
      state_q  <= state_d;
      we       <= we_d;
      a_ack    <= a_ack_d;
      b_ack    <= b_ack_d;
      addr     <= addr_d;
      ram_d    <= data_d;
      last_b_q <= last_b_d;
      vpos_q   <= vpos;
      vpos_qq  <= vpos_q;
    end
  end

`ifdef FB_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clr_q <= '0;
    else       clr_q <= clr_d;
  end
`endif

endmodule
